mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter (state, owner, request payload).
package mem_arb_pkg;

  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned ADDR_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    arb_owner_e        owner;
    logic              write;
    logic [ADDR_W-1:0] addr;
  } arb_req_t;

  // The side that did not win the previous grant.
  function automatic arb_owner_e other_side(input arb_owner_e last);
    return (last == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (icache / dcache) arbiter in front of a single-port line memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed dcache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [31:0]       i_addr_i,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [31:0]       d_addr_i,
  input  logic [LINE_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] rd_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  arb_req_t          r_req;
  logic [LINE_W-1:0] r_data;
  logic              w_any_req;
  logic              w_grant_d;
  logic              w_mem_done;

  assign w_any_req  = i_req_i | d_req_i;
  assign w_mem_done = (r_state == ST_BUSY) & mem_ack_i;

`ifdef MEM_ARB_RR_EN
  arb_owner_e r_last;

  // On a tie, serve whichever side did not win last time.
  assign w_grant_d = d_req_i & (~i_req_i | (other_side(r_last) == OWN_D));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last <= OWN_I;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_last <= w_grant_d ? OWN_D : OWN_I;
    end
  end
`else
  assign w_grant_d = d_req_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_ack_i) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning request; memory side is driven only from these copies.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_req  <= '0;
      r_data <= '0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_req.owner <= w_grant_d ? OWN_D : OWN_I;
      r_req.write <= w_grant_d & d_write_i;
      r_req.addr  <= w_grant_d ? d_addr_i : i_addr_i;
      r_data      <= w_grant_d ? d_data_i : '0;
    end
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    i_ack_o      = 1'b0;
    d_ack_o      = 1'b0;
    rd_data_o    = '0;
    mem_addr_o   = r_req.addr;
    mem_data_o   = r_data;
    if (r_state == ST_BUSY) begin
      mem_enable_o = 1'b1;
      mem_write_o  = r_req.write & (r_req.owner == OWN_D);
    end
    if (w_mem_done) begin
      i_ack_o   = (r_req.owner == OWN_I);
      d_ack_o   = (r_req.owner == OWN_D);
      rd_data_o = mem_data_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; memory model returns {8{addr ^ 32'hA5A50000}}.
module tb_mem_arbiter;

  localparam int unsigned LW = 256;
  localparam logic [LW-1:0] L_400  = {8{32'hA5A5_0400}};
  localparam logic [LW-1:0] L_800  = {8{32'hA5A5_0800}};
  localparam logic [LW-1:0] L_1000 = {8{32'hA5A5_1000}};
  localparam logic [LW-1:0] L_2000 = {8{32'hA5A5_2000}};
  localparam logic [LW-1:0] D_AB   = {32{8'hAB}};

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          i_req_i, d_req_i, d_write_i;
  logic [31:0]   i_addr_i, d_addr_i;
  logic [LW-1:0] d_data_i;
  logic          i_ack_o, d_ack_o;
  logic [LW-1:0] rd_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_data_o, mem_data_i;
  logic          mem_ack_i;

  logic          model_ack, man_ack;
  bit            model_en;
  int            lat;
  int            cnt;
  int            n_cmp, n_fail;

  mem_arbiter #(.LINE_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_data_i(d_data_i), .d_ack_o(d_ack_o), .rd_data_o(rd_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_data_i = {8{mem_addr_o ^ 32'hA5A5_0000}};
  assign mem_ack_i  = model_ack | man_ack;

  // Memory model: ack pulses in the lat-th cycle of a continuous enable.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt       <= 0;
      model_ack <= 1'b0;
    end else begin
      model_ack <= 1'b0;
      if (model_en && mem_enable_o && !model_ack) begin
        if (cnt >= lat - 2) begin
          model_ack <= 1'b1;
          cnt       <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max_cyc, output bit saw_i, output bit saw_d);
    saw_i = 1'b0;
    saw_d = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      if (i_ack_o || d_ack_o) begin
        saw_i = i_ack_o;
        saw_d = d_ack_o;
        chk("ack_exclusive", LW'(i_ack_o & d_ack_o), LW'(0));
        return;
      end
    end
    chk("ack_timeout", LW'(i_ack_o | d_ack_o), LW'(1));
  endtask

  initial begin
    bit si, sd;
    bit exp_d;
    int n_ack, n_en;
    n_cmp = 0; n_fail = 0;
    model_en = 1'b1; lat = 10; man_ack = 1'b0;
    rst_i = 1'b0;
    i_req_i = 0; d_req_i = 0; d_write_i = 0;
    i_addr_i = '0; d_addr_i = '0; d_data_i = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_enable", LW'(mem_enable_o), LW'(0));
    chk("rst_write", LW'(mem_write_o), LW'(0));
    chk("rst_addr", LW'(mem_addr_o), LW'(0));
    chk("rst_acks", LW'({i_ack_o, d_ack_o}), LW'(0));
    chk("rst_rdata", rd_data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Instruction read at 0x400, 10-cycle memory latency
    i_req_i = 1'b1; i_addr_i = 32'h400;
    chk("t1_c0_enable", LW'(mem_enable_o), LW'(0));
    n_ack = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("t1_enable", LW'(mem_enable_o), LW'(1));
      n_ack += int'(i_ack_o) + int'(d_ack_o);
    end
    chk("t1_no_early_ack", LW'(n_ack), LW'(0));
    chk("t1_addr", LW'(mem_addr_o), LW'(32'h400));
    chk("t1_write", LW'(mem_write_o), LW'(0));
    tick();
    chk("t1_c10_enable", LW'(mem_enable_o), LW'(1));
    chk("t1_i_ack", LW'(i_ack_o), LW'(1));
    chk("t1_d_ack", LW'(d_ack_o), LW'(0));
    chk("t1_rdata", rd_data_o, L_400);
    i_req_i = 1'b0;
    tick();
    chk("t1_gap_enable", LW'(mem_enable_o), LW'(0));
    chk("t1_gap_ack", LW'(i_ack_o), LW'(0));
    chk("t1_gap_rdata", rd_data_o, '0);
    tick();

    // Simultaneous requests: dcache write-back first, then instruction read
    lat = 3;
    i_req_i = 1'b1; i_addr_i = 32'h800;
    d_req_i = 1'b1; d_write_i = 1'b1; d_addr_i = 32'h1000; d_data_i = D_AB;
    tick();
    chk("t2_enable", LW'(mem_enable_o), LW'(1));
    chk("t2_write", LW'(mem_write_o), LW'(1));
    chk("t2_addr", LW'(mem_addr_o), LW'(32'h1000));
    chk("t2_wdata", mem_data_o, D_AB);
    wait_ack(20, si, sd);
    chk("t2_first_d", LW'({si, sd}), LW'(2'b01));
    d_req_i = 1'b0; d_write_i = 1'b0;
    tick();
    chk("t2_gap_enable", LW'(mem_enable_o), LW'(0));
    tick();
    chk("t2_idle_enable", LW'(mem_enable_o), LW'(0));
    tick();
    chk("t2_i_enable", LW'(mem_enable_o), LW'(1));
    chk("t2_i_write", LW'(mem_write_o), LW'(0));
    chk("t2_i_addr", LW'(mem_addr_o), LW'(32'h800));
    wait_ack(20, si, sd);
    chk("t2_second_i", LW'({si, sd}), LW'(2'b10));
    chk("t2_i_rdata", rd_data_o, L_800);
    i_req_i = 1'b0;
    tick();
    tick();

    // Both held for 4 transactions: D,I,D,I with round-robin, else always D
    i_req_i = 1'b1; d_req_i = 1'b1; d_write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      wait_ack(30, si, sd);
      chk($sformatf("t3_grant%0d", k), LW'({si, sd}), exp_d ? LW'(2'b01) : LW'(2'b10));
      chk($sformatf("t3_rdata%0d", k), rd_data_o, exp_d ? L_1000 : L_800);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    tick();

    // Reset mid-BUSY, then a stray memory ack after release
    model_en = 1'b0;
    i_req_i = 1'b1; i_addr_i = 32'h40;
    tick();
    chk("t4_busy_enable", LW'(mem_enable_o), LW'(1));
    #2 rst_i = 1'b0;
    #1;
    chk("t4_rst_enable", LW'(mem_enable_o), LW'(0));
    chk("t4_rst_addr", LW'(mem_addr_o), LW'(0));
    chk("t4_rst_ack", LW'({i_ack_o, d_ack_o}), LW'(0));
    i_req_i = 1'b0;
    #2 rst_i = 1'b1;
    tick();
    man_ack = 1'b1;
    #1;
    chk("t4_late_ack", LW'({i_ack_o, d_ack_o}), LW'(0));
    chk("t4_late_rdata", rd_data_o, '0);
    tick();
    man_ack = 1'b0;
    chk("t4_idle_enable", LW'(mem_enable_o), LW'(0));
    model_en = 1'b1;
    tick();

    // dcache drops its request after grant; transaction still completes once
    lat = 4;
    d_req_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h2000;
    tick();
    chk("t5_enable", LW'(mem_enable_o), LW'(1));
    chk("t5_write", LW'(mem_write_o), LW'(0));
    d_req_i = 1'b0;
    wait_ack(20, si, sd);
    chk("t5_d_ack", LW'({si, sd}), LW'(2'b01));
    chk("t5_rdata", rd_data_o, L_2000);
    n_ack = 0; n_en = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_ack += int'(d_ack_o) + int'(i_ack_o);
      n_en  += int'(mem_enable_o);
    end
    chk("t5_no_reack", LW'(n_ack), LW'(0));
    chk("t5_no_regrant", LW'(n_en), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
